down_timer8: RTL and testbench

Loadable 8-bit down-counting timer with terminal-count pulse and optional auto-reload. It is the decrementing counterpart of the up counter in the sequential library. A preset value is loaded, a start command copies it into the count register, and the block counts down on each enabled cycle to zero. It sits beside the register/counter blocks and drives timeouts, delays and periodic ticks in the datapath controller.

---
 rtl/down_timer8.sv | 92 +++++++++
 tb/tb_down_timer8.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer8.sv
// Loadable down-counting timer: load/start/stop control, one-cycle done pulse at
// terminal count, optional auto-reload from the preset register.
module down_timer8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             EN,
   input  logic             load,
   input  logic             start,
   input  logic             stop,
   input  logic             auto,
   input  logic [WIDTH-1:0] CNT_In,
   output logic [WIDTH-1:0] CNT,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_preset;
   logic [WIDTH-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;

   // Terminal edge: an enabled tick while the count sits at 1 (0 is never seen in RUN).
   logic w_terminal;
   assign w_terminal = EN && (r_cnt <= {{(WIDTH-1){1'b0}}, 1'b1});

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state  <= IDLE;
         r_preset <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (load) begin
            r_preset <= CNT_In;
            r_cnt    <= CNT_In;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     if (r_preset != '0) begin
                        r_cnt   <= r_preset;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                     end else begin
                        r_cnt  <= '0;
                        r_done <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (stop) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else if (w_terminal) begin
                     r_done <= 1'b1;
                     if (auto) begin
                        r_cnt <= r_preset;
                     end else begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else if (EN) begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign CNT  = r_cnt;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_down_timer8.sv
// Self-checking bench for down_timer8: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_down_timer8;

   logic       clk;
   logic       res;
   logic       EN;
   logic       load;
   logic       start;
   logic       stop;
   logic       auto;
   logic [7:0] CNT_In;
   logic [7:0] CNT;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int m_preset;
   int m_cnt;
   bit m_run;
   bit m_done;

   down_timer8 #(.WIDTH(8)) dut (
      .clk    (clk),
      .res    (res),
      .EN     (EN),
      .load   (load),
      .start  (start),
      .stop   (stop),
      .auto   (auto),
      .CNT_In (CNT_In),
      .CNT    (CNT),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_preset = 0;
      m_cnt    = 0;
      m_run    = 0;
      m_done   = 0;
   endtask

   // One clock edge of the specified behaviour, priority load > stop > start > count.
   task automatic model_step();
      m_done = 0;
      if (!res) begin
         model_reset();
      end else if (load) begin
         m_preset = int'(CNT_In);
         m_cnt    = int'(CNT_In);
         m_run    = 0;
      end else if (m_run && stop) begin
         m_run = 0;
      end else if (!m_run && start) begin
         if (m_preset != 0) begin
            m_cnt = m_preset;
            m_run = 1;
         end else begin
            m_cnt  = 0;
            m_done = 1;
         end
      end else if (m_run && EN) begin
         if (m_cnt == 1) begin
            m_done = 1;
            if (auto) m_cnt = m_preset;
            else begin
               m_cnt = 0;
               m_run = 0;
            end
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("cnt",  {24'd0, CNT}, m_cnt[31:0]);
      chk("busy", {31'd0, busy}, {31'd0, m_run});
      chk("done", {31'd0, done}, {31'd0, m_done});
   endtask

   task automatic idle_inputs();
      EN = 0; load = 0; start = 0; stop = 0; auto = 0; CNT_In = 8'h00;
   endtask

   task automatic do_load(input logic [7:0] v);
      idle_inputs();
      load = 1; CNT_In = v;
      tick();
      load = 0;
   endtask

   task automatic do_start();
      start = 1;
      tick();
      start = 0;
   endtask

   initial begin
      int n;
      int en_cnt;
      int done_cnt;
      int busy_cnt;

      // Reset held from time zero, across several clock edges
      res = 0;
      idle_inputs();
      model_reset();
      #2;
      chk("rst_cnt",  {24'd0, CNT}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      repeat (3) tick();
      res = 1;
      repeat (10) tick();

      // One-shot from 5
      do_load(8'h05);
      do_start();
      chk("os_start_cnt", {24'd0, CNT}, 32'd5);
      EN = 1;
      busy_cnt = 1;
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            chk("os_done_cnt0", {24'd0, CNT}, 32'd0);
         end
      end
      chk("os_busy_len", busy_cnt, 32'd5);
      chk("os_done_num", done_cnt, 32'd1);
      tick();
      EN = 0;

      // Auto-reload, preset 3, random EN gaps
      do_load(8'h03);
      auto = 1;
      do_start();
      en_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         EN = 1'($urandom_range(0, 1));
         if (EN) en_cnt++;
         tick();
         if (done) done_cnt++;
         chk("auto_nz",   {31'd0, CNT != 8'd0}, 32'd1);
         chk("auto_busy", {31'd0, busy}, 32'd1);
      end
      chk("auto_pulses", done_cnt, en_cnt / 3);
      EN = 0; stop = 1;
      tick();
      stop = 0; auto = 0;

      // stop collides with terminal edge
      do_load(8'h02);
      do_start();
      EN = 1;
      tick();
      chk("pri_cnt1", {24'd0, CNT}, 32'd1);
      stop = 1;
      tick();
      stop = 0;
      chk("pri_stop_cnt",  {24'd0, CNT}, 32'd1);
      chk("pri_stop_done", {31'd0, done}, 32'd0);
      EN = 0;
      // load collides with terminal edge
      do_start();
      EN = 1;
      tick();
      load = 1; CNT_In = 8'hA0;
      tick();
      load = 0; EN = 0;
      chk("pri_load_cnt", {24'd0, CNT}, 32'hA0);
      // start during RUN is ignored
      do_start();
      EN = 1;
      tick();
      start = 1;
      tick();
      start = 0;
      chk("pri_rstart", {24'd0, CNT}, 32'h9E);
      EN = 0; stop = 1;
      tick();
      stop = 0;

      // Zero preset
      do_load(8'h00);
      do_start();
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_busy", {31'd0, busy}, 32'd0);
      tick();

      // Max preset: done after exactly 255 enabled edges
      do_load(8'hFF);
      do_start();
      EN = 1;
      n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      chk("max_edges", n, 32'd255);
      EN = 0;
      tick();

      // Async reset mid-count at CNT=7
      do_load(8'd20);
      do_start();
      EN = 1;
      repeat (13) tick();
      chk("ar_pre_cnt", {24'd0, CNT}, 32'd7);
      #2;
      res = 0;
      #1;
      model_reset();
      chk("ar_cnt",  {24'd0, CNT}, 32'd0);
      chk("ar_busy", {31'd0, busy}, 32'd0);
      chk("ar_done", {31'd0, done}, 32'd0);
      EN = 0;
      repeat (2) tick();
      res = 1;
      tick();
      do_start();
      chk("ar_zero_done", {31'd0, done}, 32'd1);
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         EN     = 1'($urandom_range(0, 3) != 0);
         load   = 1'($urandom_range(0, 19) == 0);
         start  = 1'($urandom_range(0, 5) == 0);
         stop   = 1'($urandom_range(0, 29) == 0);
         auto   = 1'($urandom_range(0, 1));
         CNT_In = 8'($urandom_range(0, 12));
         tick();
      end
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
